// File: rtl/adder_seq_ctrl_if.sv
// adder_seq_ctrl_if: operand/result handshake bundle for the sliced sequential adder
interface adder_seq_ctrl_if #(parameter int DATA_W = 16);
  logic              start_valid;
  logic              start_ready;
  logic [DATA_W-1:0] din_one;
  logic [DATA_W-1:0] din_two;
  logic              cin;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              busy;
  modport master (
    output start_valid, din_one, din_two, cin, res_ready,
    input  start_ready, res_valid, sum, cout, busy
  );
  modport slave (
    input  start_valid, din_one, din_two, cin, res_ready,
    output start_ready, res_valid, sum, cout, busy
  );
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: DATA_W-bit add computed one 4-bit slice per clock through a single adder_4bit
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0, ci};
endmodule

module adder_seq_ctrl #(parameter int DATA_W = 16) (
  input logic clk,
  input logic rst_n,
  adder_seq_ctrl_if.slave bus
);
  localparam int NSLICE = DATA_W / 4;
  localparam int IW = $clog2(NSLICE);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [DATA_W-1:0] op_one, op_two, sum_r;
  logic carry, cout_r, last, co;
  logic [3:0] s;
  assign last = idx == IW'(NSLICE - 1);
  adder_4bit u_add (
    .a (op_one[{idx, 2'b00} +: 4]),
    .b (op_two[{idx, 2'b00} +: 4]),
    .ci(carry),
    .s (s),
    .co(co)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (bus.start_valid ? CALC : IDLE) :
               state == CALC ? (last ? DONE : CALC) :
               state == DONE ? (bus.res_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx    <= '0;
      op_one <= '0;
      op_two <= '0;
      carry  <= 1'b0;
      sum_r  <= '0;
      cout_r <= 1'b0;
    end else if (state == IDLE && bus.start_valid) begin
      op_one <= bus.din_one;
      op_two <= bus.din_two;
      carry  <= bus.cin;
      sum_r  <= '0;
      idx    <= '0;
    end else if (state == CALC) begin
      sum_r[{idx, 2'b00} +: 4] <= s;
      carry <= co;
      idx   <= last ? '0 : idx + 1'b1;
      if (last) cout_r <= co;
    end
  // ready is masked by rst_n so nothing is offered while reset is held
  assign bus.start_ready = state == IDLE && rst_n;
  assign bus.res_valid   = state == DONE;
  assign bus.busy        = state != IDLE;
  assign bus.sum         = sum_r;
  assign bus.cout        = cout_r;
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
Sequencing controller that performs a DATA_W-bit add by reusing one instantiated adder_4bit, one 4-bit slice per clock. The ripple carry is held in a carry register between slices. Operands arrive and results leave over valid/ready handshakes. The block sits between a requesting master and any consumer that can tolerate multi-cycle latency in exchange for a single 4-bit adder.

Parameters:
DATA_W, 16, operand/result width; must be a multiple of 4 and at least 8.
NSLICE (localparam), DATA_W/4, number of 4-bit slices and of CALC cycles.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
start_valid  input  1  requester presents an operation
start_ready  output  1  block can accept an operation (high only in IDLE)
din_one  input  DATA_W  first operand
din_two  input  DATA_W  second operand
cin  input  1  carry in to slice 0
res_valid  output  1  result available (high only in DONE)
res_ready  input  1  consumer accepts result
sum  output  DATA_W  registered result
cout  output  1  registered carry out of top slice
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; slice index=0; operand, carry, sum and cout registers cleared to 0; res_valid=0; busy=0; start_ready=0 while rst_n low, 1 from the first cycle after release.
- The FSM has three states: IDLE, CALC, DONE. Outputs are decoded from state:
  - start_ready = (state==IDLE)
  - res_valid = (state==DONE)
  - busy = (state!=IDLE)
- IDLE: on a rising edge with start_valid & start_ready, capture din_one, din_two and cin into internal registers; clear the sum register; set index=0; go to CALC. No accept means remain in IDLE.
- CALC: adder_4bit is driven combinationally with op_one[4*idx+3:4*idx], op_two[4*idx+3:4*idx] and the carry register. On each edge:
  - write the slice result into sum[4*idx+3:4*idx];
  - carry register <= adder cout;
  - idx <= idx+1.
  On the edge that processes idx==NSLICE-1: cout <= adder cout; idx <= 0; go to DONE.
- DONE: sum and cout are held stable. On an edge with res_ready=1, go to IDLE. sum and cout keep their values until the next accept clears sum.
- Latency: if the accept happens at edge T0, res_valid is high from edge T0+NSLICE. Minimum accept-to-accept spacing is NSLICE+2 cycles: a new start is never accepted in the DONE handshake cycle.
- While busy: start_valid is ignored and start_ready=0; din_one, din_two and cin changes after the accept have no effect on the result.
- res_ready asserted outside DONE has no effect.
- Arithmetic: {cout,sum} = din_one + din_two + cin, modulo 2^(DATA_W+1), exact for all inputs.
- Reset mid-operation (CALC or DONE): the partial or pending result is discarded and all registers return to reset values immediately. No res_valid is generated for the aborted operation.
- Simultaneous start_valid and reset release: no accept occurs in the edge while rst_n is low.
- No combinational path from start_valid to start_ready, or from res_ready to res_valid.

Test Plan:
- Basic add: 0x1234 + 0x4321, cin=0, res_ready=1 -> sum=0x5555, cout=0; res_valid rises exactly 4 clocks after the accept edge and is high for 1 cycle.
- Full carry ripple: 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1. Then 0xFFFF + 0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Then 0x0000 + 0x0000, cin=1 -> sum=0x0001, cout=0.
- Backpressure: 0x00F0 + 0x0F10, cin=0, with res_ready held low 5 cycles -> res_valid=1, sum=0x1000, cout=0 stable throughout; start_ready=0; start_valid pulses in this window are not accepted. Raising res_ready -> IDLE and start_ready=1 on the next cycle.
- Operand isolation: change din_one/din_two/cin every cycle after the accept of 0x8000 + 0x8000, cin=0 -> sum=0x0000, cout=1.
- Reset mid-CALC: pull rst_n low after 2 CALC edges -> sum=0, cout=0, busy=0, res_valid=0 immediately. After release, 0x0101 + 0x0202, cin=1 -> sum=0x0304, cout=0.
- Random regression: 1000 random operations with random res_ready stalls, DATA_W=16 and DATA_W=8, checked against a behavioural model -> zero mismatches; accept spacing never below NSLICE+2.
